// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
// Holds the FSM state type, default parameter values and the
// alignment-mask helper used by the target-alignment block.
package pc_pkg;

   // Two-state sequencer: one idle cycle after reset, then issue.
   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } pc_state_t;

   // Default address width and vectors; widths follow PC_XLEN.
   localparam int              PC_XLEN         = 32;
   localparam logic [31:0]     PC_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0]     PC_TRAP_VECTOR  = 32'h0000_0100;
   localparam int              PC_INSTR_BYTES  = 4;

   // Mask with the low lsb_bits bits set. Returned at 64 bits so any
   // XLEN up to 64 can take the slice it needs.
   function automatic logic [63:0] low_mask(input int unsigned lsb_bits);
      logic [63:0] m;
      m = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (i < lsb_bits) begin
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage : pc_pkg

// File: rtl/pc_align.sv
// Combinational redirect-target alignment.
// Clears the low log2(INSTR_BYTES) bits of a target address and flags
// whether any of those bits were set (a misaligned target).
module pc_align
   import pc_pkg::*;
#(
   parameter int XLEN        = PC_XLEN,
   parameter int INSTR_BYTES = PC_INSTR_BYTES
) (
   input  logic [XLEN-1:0] target,
   output logic [XLEN-1:0] aligned,
   output logic            misaligned
);

   // Number of address bits covered by one instruction.
   localparam int unsigned LSB = $clog2(INSTR_BYTES);

   // Mask of the in-instruction offset bits, sized to XLEN.
   localparam logic [63:0]     MASK_WIDE = low_mask(LSB);
   localparam logic [XLEN-1:0] LOW_MASK  = MASK_WIDE[XLEN-1:0];

   // Per-bit alignment: offset bits forced low, the rest pass through.
   generate
      for (genvar gi = 0; gi < XLEN; gi++) begin : g_align_bit
         if (gi < LSB) begin : g_offset
            assign aligned[gi] = 1'b0;
         end else begin : g_keep
            assign aligned[gi] = target[gi];
         end
      end
   endgenerate

   // Any set offset bit means the target is not instruction-aligned.
   assign misaligned = |(target & LOW_MASK);

endmodule : pc_align

// File: rtl/pc_gen.sv
// Program-counter generator.
// Holds the fetch address, issues it over a valid/ready handshake,
// advances on every accepted fetch, and reloads on redirect while
// toggling an epoch bit so downstream can drop stale in-flight fetches.
// Optional misaligned-redirect trapping is enabled by defining
// PC_MISALIGN_TRAP_EN; without it, misaligned targets are silently
// aligned and misalign/misalign_addr are tied to zero.
module pc_gen
   import pc_pkg::*;
#(
   parameter int              XLEN         = PC_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
   parameter int              INSTR_BYTES  = PC_INSTR_BYTES,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] fetch_pc,
   output logic            fetch_epoch,
   output logic            misalign,
   output logic [XLEN-1:0] misalign_addr
);

   // Increment applied per accepted fetch, at address width.
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

   pc_state_t       state_reg;
   logic [XLEN-1:0] pc_reg;
   logic            epoch_reg;
   logic            accept;
   logic [XLEN-1:0] aligned_target;
   logic            target_misaligned;
   logic [XLEN-1:0] redirect_next;

   pc_align #(
      .XLEN        (XLEN),
      .INSTR_BYTES (INSTR_BYTES)
   ) u_align (
      .target     (redirect_pc),
      .aligned    (aligned_target),
      .misaligned (target_misaligned)
   );

   // Request is offered only in RUN and only while the pipe is not stalled.
   assign fetch_valid = (state_reg == RUN) && !stall;
   assign accept      = fetch_valid && fetch_ready;
   assign fetch_pc    = pc_reg;
   assign fetch_epoch = epoch_reg;

`ifdef PC_MISALIGN_TRAP_EN
   logic            misalign_reg;
   logic [XLEN-1:0] misalign_addr_reg;

   // Misaligned targets divert to the trap vector instead of being masked.
   assign redirect_next = target_misaligned ? TRAP_VECTOR : aligned_target;

   // One-cycle pulse alongside the new PC; faulting address is sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_reg      <= 1'b0;
         misalign_addr_reg <= '0;
      end else begin
         misalign_reg <= redirect_valid && target_misaligned;
         if (redirect_valid && target_misaligned) begin
            misalign_addr_reg <= redirect_pc;
         end
      end
   end

   assign misalign      = misalign_reg;
   assign misalign_addr = misalign_addr_reg;
`else
   logic unused_trap;

   // Without trapping the target is simply aligned.
   assign redirect_next = aligned_target;

   // The detect output and trap vector have no consumer in this build.
   assign unused_trap   = target_misaligned ^ (^TRAP_VECTOR);

   assign misalign      = 1'b0;
   assign misalign_addr = '0;
`endif

   // Sequencer, PC and epoch: reset > redirect > accept > hold.
   // A redirect in the same cycle as an accept lets the accepted request
   // complete at the old PC/epoch; the new target is issued next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= BOOT;
         pc_reg    <= RESET_VECTOR;
         epoch_reg <= 1'b0;
      end else begin
         // BOOT lasts exactly one cycle regardless of stall; RUN persists.
         state_reg <= RUN;
         if (redirect_valid) begin
            pc_reg    <= redirect_next;
            epoch_reg <= ~epoch_reg;
         end else if (accept) begin
            pc_reg    <= pc_reg + PC_STEP;
         end
      end
   end

endmodule : pc_gen
